// File: rtl/hazard_pkg.sv
// Shared types for the hazard/forwarding scoreboard: operand select encoding,
// the per-stage shadow tag and the "stage writes register r" predicate.
package hazard_pkg;

  // Tag fields are sized for the widest register index we expect; narrower
  // REG_ADDR_W values are zero-extended into them at the top level.
  localparam int TAG_ADDR_W = 8;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_t;

  typedef struct packed {
    logic                  valid;
    logic [TAG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  is_load;
    logic [TAG_ADDR_W-1:0] rs1;
    logic [TAG_ADDR_W-1:0] rs2;
    logic                  use_rs1;
    logic                  use_rs2;
  } stage_tag_t;

  localparam stage_tag_t TAG_NONE = '0;

  // x0 is hardwired, so a write to it never produces a hazard or a forward.
  function automatic logic writes_reg(stage_tag_t tag, logic [TAG_ADDR_W-1:0] r);
    return tag.valid && tag.reg_write && (tag.rd == r) && (tag.rd != '0);
  endfunction

endpackage

// File: rtl/hazard_tag_stage.sv
// One registered shadow-pipeline stage holding a stage_tag_t.
module hazard_tag_stage
  import hazard_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       invalidate,
  input  logic       load_en,
  input  stage_tag_t d,
  output stage_tag_t q
);

  // Invalidate takes priority over load so bubbles and clears always win.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)        q <= TAG_NONE;
    else if (invalidate) q <= TAG_NONE;
    else if (load_en)    q <= d;
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard, forwarding and flush controller for the 5-stage RV32I pipeline.
// Tracks ID->EX->MEM->WB tags and derives stall, flushes and EX operand
// forwarding selects; counts stall and redirect cycles (saturating).
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,   // must not exceed TAG_ADDR_W
  parameter int FORWARDING = 1,
  parameter int CNT_W      = 16
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  CLEAR,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_is_load,
  input  logic                  redirect_mem,
  output logic                  stall,
  output logic                  flush_if_id,
  output logic                  flush_id_ex,
  output logic                  flush_ex_mem,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
);

  stage_tag_t id_tag, ex_tag, mem_tag, wb_tag;
  logic       stall_raw;
  logic       redirect;
  logic       hit_ex, hit_mem, hit_wb;
  fwd_sel_t   sel_a, sel_b;
  logic       unused_wb;

  // Only WB's destination fields are consulted; source fields just ride along.
  assign unused_wb = ^{wb_tag.is_load, wb_tag.rs1, wb_tag.rs2, wb_tag.use_rs1, wb_tag.use_rs2};

  // Pack the ID-stage instruction into a tag.
  always_comb begin
    id_tag           = TAG_NONE;
    id_tag.valid     = id_valid;
    id_tag.rd        = TAG_ADDR_W'(id_rd);
    id_tag.reg_write = id_reg_write;
    id_tag.is_load   = id_is_load;
    id_tag.rs1       = TAG_ADDR_W'(id_rs1);
    id_tag.rs2       = TAG_ADDR_W'(id_rs2);
    id_tag.use_rs1   = id_use_rs1;
    id_tag.use_rs2   = id_use_rs2;
  end

  // Detect ID-source dependencies on each older stage and form the raw stall.
  always_comb begin
    hit_ex  = (id_use_rs1 && writes_reg(ex_tag,  id_tag.rs1)) || (id_use_rs2 && writes_reg(ex_tag,  id_tag.rs2));
    hit_mem = (id_use_rs1 && writes_reg(mem_tag, id_tag.rs1)) || (id_use_rs2 && writes_reg(mem_tag, id_tag.rs2));
    hit_wb  = (id_use_rs1 && writes_reg(wb_tag,  id_tag.rs1)) || (id_use_rs2 && writes_reg(wb_tag,  id_tag.rs2));
    if (FORWARDING != 0) stall_raw = id_valid && ex_tag.valid && ex_tag.is_load && hit_ex;
    else                 stall_raw = id_valid && (hit_ex || hit_mem || hit_wb);
  end

  // Redirect beats stall; CLEAR silences everything for its cycle.
  always_comb begin
    redirect     = redirect_mem && !CLEAR;
    stall        = stall_raw && !redirect_mem && !CLEAR;
    flush_if_id  = redirect;
    flush_id_ex  = redirect;
    flush_ex_mem = redirect;
  end

  // EX operand selects: MEM (non-load) beats WB; bubbles and unused sources read the regfile.
  always_comb begin
    sel_a = FWD_REG;
    sel_b = FWD_REG;
    if (FORWARDING != 0 && !CLEAR && ex_tag.valid) begin
      if (ex_tag.use_rs1) begin
        if (writes_reg(mem_tag, ex_tag.rs1) && !mem_tag.is_load) sel_a = FWD_MEM;
        else if (writes_reg(wb_tag, ex_tag.rs1))                 sel_a = FWD_WB;
      end
      if (ex_tag.use_rs2) begin
        if (writes_reg(mem_tag, ex_tag.rs2) && !mem_tag.is_load) sel_b = FWD_MEM;
        else if (writes_reg(wb_tag, ex_tag.rs2))                 sel_b = FWD_WB;
      end
    end
    fwd_a = sel_a;
    fwd_b = sel_b;
  end

  hazard_tag_stage u_ex (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .invalidate (CLEAR || stall || redirect_mem || !id_valid),
    .load_en    (1'b1),
    .d          (id_tag),
    .q          (ex_tag)
  );

  hazard_tag_stage u_mem (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .invalidate (CLEAR || redirect_mem),
    .load_en    (1'b1),
    .d          (ex_tag),
    .q          (mem_tag)
  );

  hazard_tag_stage u_wb (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .invalidate (CLEAR),
    .load_en    (1'b1),
    .d          (mem_tag),
    .q          (wb_tag)
  );

  // Saturating performance counters; CLEAR deliberately leaves them alone.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall && (stall_count != '1))    stall_count <= stall_count + CNT_W'(1);
      if (redirect && (flush_count != '1)) flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule
